// File: rtl/blake_nonce_feeder.sv
// Nonce scheduler and result checker wrapped around one blake_64 core.
// Sweeps an inclusive nonce range (with 32-bit wrap), paces core_ena at the
// core's acceptance rate, tags in-flight nonces in order, and latches the
// first result whose hash is at or below the target.
module blake_nonce_feeder #(
  parameter int ISSUE_GAP    = 65,
  parameter int MAX_INFLIGHT = 2,
  parameter int CW           = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         start,
  input  logic         abort,
  input  logic [639:0] header_in,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [511:0] target,
  output logic         core_ena,
  output logic [639:0] core_din,
  input  logic         core_rdy,
  input  logic [511:0] core_dout,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [511:0] found_hash,
  output logic         done,
  output logic         exhausted,
  output logic         tag_err
);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int NW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;
  state_t r_state, w_next;

  // r_din doubles as the header store: loaded with the template on start,
  // then holds the last issued word so core_din stays stable between issues.
  logic [639:0] r_din;
  logic [31:0]  r_cur, r_end;
  logic [511:0] r_target;
  logic [CW-1:0] r_gap;
  logic [31:0]  r_fifo [MAX_INFLIGHT];
  logic [PW-1:0] r_rd, r_wr;
  logic [NW-1:0] r_cnt;
  logic         r_found, r_exh, r_tag_err, r_range_done, r_abort_seen;
  logic [31:0]  r_found_nonce;
  logic [511:0] r_found_hash;

  logic w_accept, w_issue, w_last, w_pop, w_hit_new;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_issue   = (r_state == S_RUN) && (r_gap == '0) && (r_cnt < NW'(MAX_INFLIGHT));
  assign w_last    = w_issue && (r_cur == r_end);
  // A result with no tag outstanding cannot be attributed; it only flags tag_err.
  assign w_pop     = (r_state != S_IDLE) && core_rdy && (r_cnt != '0);
  assign w_hit_new = w_pop && !r_found && (core_dout <= r_target);

  assign core_ena    = w_issue;
  assign core_din    = w_issue ? {r_din[639:32], r_cur} : r_din;
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_FIN);
  assign found       = r_found;
  assign found_nonce = r_found_nonce;
  assign found_hash  = r_found_hash;
  assign exhausted   = r_exh;
  assign tag_err     = r_tag_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rstb) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; hit or abort in RUN stops issuing immediately.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last || w_hit_new || abort) w_next = S_DRAIN;
      S_DRAIN: if (r_cnt == '0) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job capture, nonce walk and issue pacing. Gap is cleared on start so a
  // new job always issues the cycle after start (the core is idle by then).
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_din        <= '0;
      r_cur        <= '0;
      r_end        <= '0;
      r_target     <= '0;
      r_gap        <= '0;
      r_range_done <= 1'b0;
      r_abort_seen <= 1'b0;
    end else if (w_accept) begin
      r_din        <= header_in;
      r_cur        <= nonce_start;
      r_end        <= nonce_end;
      r_target     <= target;
      r_gap        <= '0;
      r_range_done <= 1'b0;
      r_abort_seen <= 1'b0;
    end else begin
      if (w_issue) begin
        r_din <= {r_din[639:32], r_cur};
        r_gap <= CW'(ISSUE_GAP - 1);
        if (w_last) r_range_done <= 1'b1;
        else        r_cur        <= r_cur + 32'd1;
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
      if ((r_state == S_RUN) && abort) r_abort_seen <= 1'b1;
    end
  end

  // In-order tag FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_issue) r_wr <= (r_wr == PW'(MAX_INFLIGHT - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)   r_rd <= (r_rd == PW'(MAX_INFLIGHT - 1)) ? '0 : r_rd + 1'b1;
      case ({w_issue, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Tag storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_issue) r_fifo[r_wr] <= r_cur;
  end

  // Sticky job results; exhausted is settled on entry to FIN so it is valid with done.
  always_ff @(posedge clk) begin
    if (rstb || w_accept) begin
      r_found       <= 1'b0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
      r_exh         <= 1'b0;
      r_tag_err     <= 1'b0;
    end else begin
      if (w_hit_new) begin
        r_found       <= 1'b1;
        r_found_nonce <= r_fifo[r_rd];
        r_found_hash  <= core_dout;
      end
      if ((r_state != S_IDLE) && core_rdy && (r_cnt == '0)) r_tag_err <= 1'b1;
      if ((r_state == S_DRAIN) && (w_next == S_FIN))
        r_exh <= !r_found && r_range_done && !r_abort_seen;
    end
  end
endmodule

// File: tb/tb_blake_nonce_feeder.sv
// Bench for blake_nonce_feeder: a behavioural stand-in core returns results
// LAT cycles after each issue; expected nonces are queued per job and popped
// as core_ena pulses are observed.
module tb_blake_nonce_feeder;
  localparam int LAT = 150;
  localparam logic [639:0] HDR   = {64'h000000025b4abb46, {16{32'h6d1f0a93}}, 32'h0000ac3d, 32'hDEADBEEF};
  localparam logic [511:0] H_REF = {32'hD11A7038, 32'hCC678484, {13{32'h3c5a9e01}}, 32'hBE825679};
  localparam logic [511:0] ONES  = {512{1'b1}};

  logic clk, rstb, start, abort;
  logic [639:0] header_in;
  logic [31:0]  nonce_start, nonce_end;
  logic [511:0] target;
  logic core_ena, core_rdy, busy, found, done, exhausted, tag_err;
  logic [639:0] core_din;
  logic [511:0] core_dout, found_hash;
  logic [31:0]  found_nonce;
  logic m_rdy, inj_rdy;
  logic [511:0] m_dout;

  int n_checks = 0, n_errors = 0, cyc = 0;
  int n_issue, n_rdy, first_issue, last_issue, t_start;
  bit have_last = 0;
  logic [639:0] last_din;
  logic [31:0]  exp_q[$];
  logic [639:0] core_q[$];
  int           due_q[$];

  assign core_rdy  = m_rdy | inj_rdy;
  assign core_dout = m_dout;

  blake_nonce_feeder dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort), .header_in(header_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_ena(core_ena), .core_din(core_din), .core_rdy(core_rdy), .core_dout(core_dout),
    .busy(busy), .found(found), .found_nonce(found_nonce), .found_hash(found_hash),
    .done(done), .exhausted(exhausted), .tag_err(tag_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in digest: the reference header with nonce 0x0009E22E yields H_REF,
  // everything else yields a value whose top word is above H_REF's.
  function automatic logic [511:0] fake_hash(input logic [639:0] d);
    if (d[31:0] == 32'h0009E22E && d[639:32] == HDR[639:32]) return H_REF;
    return {32'hE0000000 | {4'h0, d[27:0]}, d[479:0]};
  endfunction

  // Issue monitor, scoreboard and stand-in core, all sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    if (core_ena) begin
      n_issue++;
      if (first_issue < 0) first_issue = cyc;
      if (have_last) begin
        n_checks++;
        if (cyc - last_issue < 65) begin n_errors++; $display("FAIL issue_gap: got %0d cycles, need >= 65", cyc - last_issue); end
      end
      n_checks++;
      if (core_q.size() >= 2) begin n_errors++; $display("FAIL inflight: got %0d outstanding, max 2", core_q.size() + 1); end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++; $display("FAIL unexpected_issue: got nonce %h, expected none", core_din[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (core_din !== {HDR[639:32], e}) begin
          n_errors++; $display("FAIL issue_din: got %h, want %h", core_din, {HDR[639:32], e});
        end
      end
      last_issue = cyc; have_last = 1; last_din = core_din;
      core_q.push_back(core_din); due_q.push_back(cyc + LAT);
    end else if (have_last) begin
      n_checks++;
      if (core_din !== last_din) begin n_errors++; $display("FAIL din_stable: got %h, want %h", core_din, last_din); end
    end
    m_rdy = 0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      m_rdy = 1; m_dout = fake_hash(core_q[0]);
      void'(core_q.pop_front()); void'(due_q.pop_front());
      n_rdy++;
    end
  end

  task automatic start_job(input logic [31:0] ns, input logic [31:0] ne, input logic [511:0] tg);
    @(negedge clk);
    n_issue = 0; n_rdy = 0; first_issue = -1; have_last = 0;
    header_in = HDR; nonce_start = ns; nonce_end = ne; target = tg; start = 1; t_start = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int maxc, output bit got);
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
  endtask

  task automatic test_reset();
    rstb = 1;
    repeat (2) @(negedge clk);
    n_checks++; if ({core_ena, busy, found, done, exhausted, tag_err} !== 6'b0) begin n_errors++; $display("FAIL reset_flags: got %b, want 000000", {core_ena, busy, found, done, exhausted, tag_err}); end
    n_checks++; if (found_nonce !== 32'h0) begin n_errors++; $display("FAIL reset_found_nonce: got %h, want 0", found_nonce); end
    n_checks++; if (found_hash !== 512'h0) begin n_errors++; $display("FAIL reset_found_hash: got %h, want 0", found_hash); end
    n_checks++; if (core_din !== 640'h0) begin n_errors++; $display("FAIL reset_core_din: got %h, want 0", core_din); end
    rstb = 0;
  endtask

  task automatic test_single();
    bit got;
    exp_q.push_back(32'h0009E22E);
    start_job(32'h0009E22E, 32'h0009E22E, ONES);
    wait_done(1000, got);
    n_checks++; if (!got) begin n_errors++; $display("FAIL single_done: got timeout, want done pulse"); end
    n_checks++; if (first_issue != t_start + 1) begin n_errors++; $display("FAIL single_latency: got issue at %0d, want %0d", first_issue, t_start + 1); end
    n_checks++; if (n_issue != 1 || n_rdy != 1) begin n_errors++; $display("FAIL single_counts: got %0d issues %0d results, want 1 1", n_issue, n_rdy); end
    n_checks++; if (found !== 1'b1 || found_nonce !== 32'h0009E22E) begin n_errors++; $display("FAIL single_found: got %b %h, want 1 0009e22e", found, found_nonce); end
    n_checks++; if (found_hash !== H_REF) begin n_errors++; $display("FAIL single_hash: got %h, want %h", found_hash, H_REF); end
    n_checks++; if (exhausted !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL single_flags: got exh %b busy %b, want 0 0", exhausted, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL single_done_pulse: got done %b a cycle later, want 0", done); end
  endtask

  task automatic test_target0();
    bit got;
    exp_q.push_back(32'h0009E22E);
    start_job(32'h0009E22E, 32'h0009E22E, 512'h0);
    wait_done(1000, got);
    n_checks++; if (!got) begin n_errors++; $display("FAIL t0_done: got timeout, want done pulse"); end
    n_checks++; if (n_issue != 1) begin n_errors++; $display("FAIL t0_issues: got %0d, want 1", n_issue); end
    n_checks++; if (found !== 1'b0 || exhausted !== 1'b1) begin n_errors++; $display("FAIL t0_flags: got found %b exh %b, want 0 1", found, exhausted); end
  endtask

  task automatic test_equal_hit();
    bit got;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0009E22C + i);
    start_job(32'h0009E22C, 32'h0009E22F, H_REF);
    wait_done(2000, got);
    n_checks++; if (!got) begin n_errors++; $display("FAIL eq_done: got timeout, want done pulse"); end
    n_checks++; if (n_issue != 4 || n_rdy != 4) begin n_errors++; $display("FAIL eq_counts: got %0d issues %0d results, want 4 4", n_issue, n_rdy); end
    n_checks++; if (found !== 1'b1 || found_nonce !== 32'h0009E22E) begin n_errors++; $display("FAIL eq_found: got %b %h, want 1 0009e22e", found, found_nonce); end
    n_checks++; if (found_hash !== H_REF || exhausted !== 1'b0) begin n_errors++; $display("FAIL eq_hash: got %h exh %b, want %h 0", found_hash, exhausted, H_REF); end
  endtask

  task automatic test_hit_stop();
    bit got;
    exp_q.push_back(32'h0009E22E); exp_q.push_back(32'h0009E22F);
    start_job(32'h0009E22E, 32'h0009E237, H_REF);
    wait_done(2000, got);
    n_checks++; if (!got) begin n_errors++; $display("FAIL stop_done: got timeout, want done pulse"); end
    n_checks++; if (n_issue != 2 || n_rdy != 2) begin n_errors++; $display("FAIL stop_counts: got %0d issues %0d results, want 2 2", n_issue, n_rdy); end
    n_checks++; if (found_nonce !== 32'h0009E22E || exhausted !== 1'b0) begin n_errors++; $display("FAIL stop_found: got %h exh %b, want 0009e22e 0", found_nonce, exhausted); end
  endtask

  task automatic test_wrap();
    bit got;
    exp_q.push_back(32'hFFFFFFFE); exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h00000000); exp_q.push_back(32'h00000001);
    start_job(32'hFFFFFFFE, 32'h00000001, 512'h0);
    // A start while busy must be ignored.
    @(negedge clk); nonce_start = 32'h55; start = 1;
    @(negedge clk); start = 0;
    wait_done(2000, got);
    n_checks++; if (!got) begin n_errors++; $display("FAIL wrap_done: got timeout, want done pulse"); end
    n_checks++; if (n_issue != 4 || n_rdy != 4) begin n_errors++; $display("FAIL wrap_counts: got %0d issues %0d results, want 4 4", n_issue, n_rdy); end
    n_checks++; if (found !== 1'b0 || exhausted !== 1'b1) begin n_errors++; $display("FAIL wrap_flags: got found %b exh %b, want 0 1", found, exhausted); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL wrap_pending: got %0d nonces never issued, want 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    bit got;
    exp_q.push_back(32'h100); exp_q.push_back(32'h101);
    start_job(32'h100, 32'h163, 512'h0);
    for (int i = 0; i < 500 && n_issue < 2; i++) @(negedge clk);
    n_checks++; if (n_issue != 2) begin n_errors++; $display("FAIL abort_setup: got %0d issues, want 2", n_issue); end
    @(negedge clk); abort = 1;
    wait_done(1000, got);
    abort = 0;
    n_checks++; if (!got) begin n_errors++; $display("FAIL abort_done: got timeout, want done pulse"); end
    n_checks++; if (n_issue != 2 || n_rdy != 2) begin n_errors++; $display("FAIL abort_counts: got %0d issues %0d results, want 2 2", n_issue, n_rdy); end
    n_checks++; if (exhausted !== 1'b0 || found !== 1'b0) begin n_errors++; $display("FAIL abort_flags: got exh %b found %b, want 0 0", exhausted, found); end
  endtask

  task automatic test_tag_err();
    bit got;
    exp_q.push_back(32'h200);
    start_job(32'h200, 32'h200, ONES);
    inj_rdy = 1;  // lands in the first RUN cycle, FIFO still empty
    @(negedge clk); inj_rdy = 0;
    n_checks++; if (tag_err !== 1'b1) begin n_errors++; $display("FAIL tag_err_set: got %b, want 1", tag_err); end
    wait_done(1000, got);
    n_checks++; if (!got) begin n_errors++; $display("FAIL tag_done: got timeout, want done pulse"); end
    n_checks++; if (found !== 1'b1 || found_nonce !== 32'h200 || tag_err !== 1'b1) begin n_errors++; $display("FAIL tag_found: got %b %h tag %b, want 1 00000200 1", found, found_nonce, tag_err); end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    exp_q.push_back(32'h300); exp_q.push_back(32'h301);
    start_job(32'h300, 32'h301, ONES);
    for (int i = 0; i < 1000 && !found; i++) @(negedge clk);
    n_checks++; if (found !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL rmid_setup: got found %b busy %b, want 1 1", found, busy); end
    rstb = 1; have_last = 0;
    @(negedge clk); rstb = 0;
    n_checks++; if ({core_ena, busy, found, done, exhausted, tag_err} !== 6'b0) begin n_errors++; $display("FAIL rmid_flags: got %b, want 000000", {core_ena, busy, found, done, exhausted, tag_err}); end
    n_checks++; if (found_nonce !== 32'h0 || found_hash !== 512'h0 || core_din !== 640'h0) begin n_errors++; $display("FAIL rmid_data: got nonce %h, want zeros on nonce/hash/din", found_nonce); end
    for (int i = 0; i < 500 && (core_q.size() != 0 || m_rdy); i++) begin
      @(negedge clk); if (done) n_done++;
    end
    repeat (3) @(negedge clk);
    n_checks++; if (tag_err !== 1'b0 || busy !== 1'b0 || n_done != 0 || n_rdy != 2) begin n_errors++; $display("FAIL rmid_late: got tag %b busy %b dones %0d results %0d, want 0 0 0 2", tag_err, busy, n_done, n_rdy); end
    test_single();
  endtask

  initial begin
    rstb = 1; start = 0; abort = 0; inj_rdy = 0; m_rdy = 0; m_dout = '0;
    header_in = '0; nonce_start = '0; nonce_end = '0; target = '0;
    test_reset();
    test_single();
    test_target0();
    test_equal_hit();
    test_hit_stop();
    test_wrap();
    test_abort();
    test_tag_err();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/blake_nonce_feeder.md
Name: blake_nonce_feeder

Overview:
- Upstream work scheduler and downstream result checker wrapped around one blake_64 core.
- Takes an 80-byte header template and a nonce range, and substitutes each nonce into din[31:0].
- Issues one core_ena pulse per nonce at the core's acceptance rate and tags each outstanding nonce in an in-order FIFO.
- Compares every core_dout against a 512-bit target and reports the first nonce whose hash is at or below the target.

Parameters:
- ISSUE_GAP, 65: minimum clk cycles between consecutive core_ena pulses, counted from one pulse to the next.
- MAX_INFLIGHT, 2: depth of the nonce tag FIFO, i.e. the maximum number of hashes outstanding in the core.
- CW, 8: width of the gap counter; must satisfy 2^CW > ISSUE_GAP.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rstb  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- abort  input  1  level; stops issuing and drains outstanding work.
- header_in  input  640  header template; bits [31:0] are ignored. Captured on start.
- nonce_start  input  32  first nonce. Captured on start.
- nonce_end  input  32  last nonce, inclusive. Captured on start.
- target  input  512  hit threshold; unsigned. Captured on start.
- core_ena  output  1  one-cycle issue pulse to blake_64 ena.
- core_din  output  640  {header[639:32], nonce}; stable from the core_ena cycle until the next issue.
- core_rdy  input  1  blake_64 rdy; a one-cycle pulse per result, results arrive in issue order.
- core_dout  input  512  blake_64 dout; valid while core_rdy=1.
- busy  output  1  high in RUN and DRAIN.
- found  output  1  sticky; the job produced a hit.
- found_nonce  output  32  nonce of the first hit.
- found_hash  output  512  hash of the first hit.
- done  output  1  one-cycle pulse at job end.
- exhausted  output  1  sticky; the range completed with no hit and no abort.
- tag_err  output  1  sticky; core_rdy arrived while the tag FIFO was empty.

Behaviour:
- Reset (rstb=1 at a rising edge):
  - State goes to IDLE.
  - Tag FIFO is emptied and the gap counter is cleared.
  - core_ena, busy, found, done, exhausted and tag_err are 0.
  - found_nonce=0, found_hash=0, core_din=0.
  - A reset mid-job discards all work. core_rdy pulses after reset are ignored and do not set tag_err until the next start.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - On start, capture the inputs and set cur=nonce_start.
  - Clear found, exhausted, found_nonce and found_hash.
  - Go to RUN. The first core_ena occurs in the cycle after start (latency 1).
- RUN:
  - Issue when gap_cnt==0 and FIFO count < MAX_INFLIGHT.
  - Issuing means: core_ena=1, core_din={hdr[639:32],cur}, push cur into the FIFO, load gap_cnt=ISSUE_GAP-1.
  - gap_cnt decrements each cycle while non-zero.
  - If the issued nonce equals nonce_end, go to DRAIN. Otherwise cur=cur+1, modulo 2^32.
  - Wrap-around: nonce_end < nonce_start sweeps through 0xFFFFFFFF to 0. nonce_start==nonce_end issues exactly one nonce.
- Result handling (any state except IDLE):
  - On core_rdy, pop the FIFO head.
  - hit = (core_dout <= target), compared unsigned over 512 bits.
  - If hit and found==0: set found=1, found_nonce=head, found_hash=core_dout.
  - Later hits are ignored.
  - Issue and pop in the same cycle leave the count unchanged.
- Early stop:
  - A hit or abort in RUN moves to DRAIN at the next edge, with no further core_ena.
  - An issue in the same cycle as the hit or abort still completes and is drained.
- DRAIN: wait until the FIFO is empty, then go to FIN.
- FIN:
  - done=1 for one cycle.
  - exhausted = !found && the range completed && abort was never seen.
  - Go to IDLE.
- Ignored inputs: start outside IDLE; core_rdy in IDLE.
- Sticky outputs hold until the next accepted start or reset.

Test Plan:
- Single nonce, all-ones target:
  - header = 0x000000025b4abb46…ac3d with nonce 0x0009E22E, nonce_start=nonce_end=0x0009E22E, target = all ones.
  - Expect exactly 1 core_ena, the cycle after start.
  - Expect found=1, found_nonce=0x0009E22E, found_hash=0xD11A7038CC678484…BE825679, then done; exhausted=0.
- Same header, target=0:
  - Expect 1 issue, found=0, exhausted=1, done pulse.
- Same header, range 0x0009E22C..0x0009E22F, target = 0xD11A7038…BE825679 exactly (the hit compares equal):
  - Expect consecutive core_ena edges ≥65 cycles apart and FIFO count never above 2.
  - Expect issues to stop after the 0x0009E22E result arrives, outstanding results drained, found_nonce=0x0009E22E.
- Wrap: range 0xFFFFFFFE..0x00000001, target=0:
  - Expect nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001 in order.
  - Expect done after the 4th core_rdy; exhausted=1.
- Abort:
  - Assert abort one cycle after the 2nd issue of a 100-nonce range.
  - Expect no 3rd core_ena, done after 2 core_rdy pulses, exhausted=0.
  - Separately, inject core_rdy in RUN with the FIFO empty: expect tag_err=1.
- Reset:
  - Assert rstb for 1 cycle mid-DRAIN.
  - Expect all outputs 0 at the next edge, IDLE; late core_rdy pulses ignored with tag_err=0.
  - A new start then behaves as in the single-nonce scenario.
